pifo_dequeue_pacer: RTL and testbench

- Consumer side of the PIFO output interface.
- Issues dequeue (pop) requests into a PIFO and paces them with a token bucket.
- Holds at most one popped entry in an output register and presents it to a downstream valid/ready sink.
- Enforces the PIFO rule that push and pop never occur in the same cycle, by yielding to an enqueue-in-progress indication from the producer side.

---
 rtl/pifo_pkg.sv | 25 ++
 rtl/pifo_token_bucket.sv | 51 +++++
 rtl/pifo_dequeue_pacer.sv | 132 +++++++++++++
 tb/tb_pifo_dequeue_pacer.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/pifo_pkg.sv
// Shared types for the PIFO consumer side: head-entry layout, priority width
// derivation and the dequeue pacer state encoding.
package pifo_pkg;

  localparam int DEF_MAX_PRIORITY = 256;
  localparam int DEF_DATA_WIDTH   = 8;

  function automatic int prio_width(input int max_prio);
    return (max_prio > 1) ? $clog2(max_prio) : 1;
  endfunction

  localparam int PIFO_PRIO_WIDTH = prio_width(DEF_MAX_PRIORITY);

  typedef struct packed {
    logic [DEF_DATA_WIDTH-1:0]  data;
    logic [PIFO_PRIO_WIDTH-1:0] prio;
  } PifoEntry;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_PAUSED = 2'd1,
    ST_FLUSH  = 2'd2
  } pacer_state_e;

endpackage

// File: rtl/pifo_token_bucket.sv
// Token bucket: one token is added every REFILL_PERIOD cycles, one is spent
// per pop; the count saturates at BUCKET_DEPTH and never goes below zero.
module pifo_token_bucket #(
  parameter int  BUCKET_DEPTH  = 8,
  parameter int  REFILL_PERIOD = 4,
  localparam int TOKEN_WIDTH   = $clog2(BUCKET_DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   refill_en_i,
  input  logic                   pop_i,
  output logic [TOKEN_WIDTH-1:0] tokens_o,
  output logic                   has_token_o
);

  localparam int RCW = (REFILL_PERIOD > 1) ? $clog2(REFILL_PERIOD) : 1;
  localparam int SW  = TOKEN_WIDTH + 1;
  localparam logic [RCW-1:0]         REFILL_LAST = RCW'(REFILL_PERIOD - 1);
  localparam logic [SW-1:0]          DEPTH_S     = SW'(BUCKET_DEPTH);
  localparam logic [TOKEN_WIDTH-1:0] DEPTH_T     = TOKEN_WIDTH'(BUCKET_DEPTH);

  logic [RCW-1:0]         rcnt_q, rcnt_d;
  logic [TOKEN_WIDTH-1:0] tokens_q, tokens_d;
  logic [SW-1:0]          sum;
  logic                   refill;
  logic                   spend;

  assign has_token_o = (tokens_q != '0);
  assign tokens_o    = tokens_q;

  // Pop is subtracted before saturation, so refill+pop together is a no-op.
  always_comb begin
    refill   = refill_en_i && (rcnt_q == REFILL_LAST);
    spend    = pop_i && has_token_o;
    rcnt_d   = rcnt_q;
    if (refill_en_i) rcnt_d = (rcnt_q == REFILL_LAST) ? '0 : rcnt_q + RCW'(1);
    sum      = {1'b0, tokens_q} + SW'(refill) - SW'(spend);
    tokens_d = (sum > DEPTH_S) ? DEPTH_T : sum[TOKEN_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rcnt_q   <= '0;
      tokens_q <= DEPTH_T;
    end else begin
      rcnt_q   <= rcnt_d;
      tokens_q <= tokens_d;
    end
  end

endmodule

// File: rtl/pifo_dequeue_pacer.sv
// Paced PIFO consumer with a one-entry output register and pause/flush control.
// Define PIFO_DEQ_STATS_EN to build the pop and stall statistics counters.
module pifo_dequeue_pacer
  import pifo_pkg::*;
#(
  parameter int  MAX_PRIORITY  = 256,
  parameter int  DATA_WIDTH    = 8,
  parameter int  BUCKET_DEPTH  = 8,
  parameter int  REFILL_PERIOD = 4,
  parameter int  CNT_WIDTH     = 32,
  localparam int PRIO_WIDTH    = prio_width(MAX_PRIORITY),
  localparam int TOKEN_WIDTH   = $clog2(BUCKET_DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i__pifo_valid,
  input  logic [PRIO_WIDTH-1:0]  i__pifo_priority,
  input  logic [DATA_WIDTH-1:0]  i__pifo_data,
  output logic                   o__pifo_ready,
  output logic                   o__pifo_clear_all,
  input  logic                   i__enq_active,
  input  logic                   i__pause,
  input  logic                   i__clear_all,
  output logic                   o__data_out_valid,
  output logic [PRIO_WIDTH-1:0]  o__data_out_priority,
  output logic [DATA_WIDTH-1:0]  o__data_out,
  input  logic                   i__data_out_ready,
  output logic [TOKEN_WIDTH-1:0] o__tokens,
  output logic [CNT_WIDTH-1:0]   o__pop_count,
  output logic [CNT_WIDTH-1:0]   o__stall_count
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [PRIO_WIDTH-1:0] prio;
  } entry_t;

  pacer_state_e state_q, state_d;
  entry_t       entry_q, entry_d;
  logic         valid_q, valid_d;
  logic         has_token;
  logic         pop;
  logic         drain;

  pifo_token_bucket #(
    .BUCKET_DEPTH  (BUCKET_DEPTH),
    .REFILL_PERIOD (REFILL_PERIOD)
  ) u_bucket (
    .clk         (clk),
    .reset       (reset),
    .refill_en_i (1'b1),
    .pop_i       (pop),
    .tokens_o    (o__tokens),
    .has_token_o (has_token)
  );

  // Pause, clear and a concurrent push all veto the pop in the cycle they appear.
  assign o__pifo_ready = (state_q == ST_RUN) && !reset && !i__clear_all && !i__pause &&
                         !i__enq_active && has_token && (!valid_q || i__data_out_ready);
  assign pop   = i__pifo_valid && o__pifo_ready;
  assign drain = valid_q && i__data_out_ready;

  assign o__pifo_clear_all    = (state_q == ST_FLUSH);
  assign o__data_out_valid    = valid_q;
  assign o__data_out_priority = entry_q.prio;
  assign o__data_out          = entry_q.data;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN: begin
        if (i__clear_all)  state_d = ST_FLUSH;
        else if (i__pause) state_d = ST_PAUSED;
      end
      ST_PAUSED: begin
        if (i__clear_all)   state_d = ST_FLUSH;
        else if (!i__pause) state_d = ST_RUN;
      end
      ST_FLUSH: state_d = i__pause ? ST_PAUSED : ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  always_comb begin
    valid_d = valid_q;
    entry_d = entry_q;
    if (i__clear_all || (state_q == ST_FLUSH)) begin
      valid_d = 1'b0;
    end else if (pop) begin
      valid_d = 1'b1;
      entry_d = '{data: i__pifo_data, prio: i__pifo_priority};
    end else if (drain) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
      valid_q <= 1'b0;
      entry_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      entry_q <= entry_d;
    end
  end

`ifdef PIFO_DEQ_STATS_EN
  logic [CNT_WIDTH-1:0] pop_cnt_q, stall_cnt_q;
  logic                 stall;

  assign stall = i__pifo_valid && (state_q == ST_RUN) && !has_token;

  always_ff @(posedge clk) begin
    if (reset) begin
      pop_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (pop)   pop_cnt_q   <= pop_cnt_q + CNT_WIDTH'(1);
      if (stall) stall_cnt_q <= stall_cnt_q + CNT_WIDTH'(1);
    end
  end

  assign o__pop_count   = pop_cnt_q;
  assign o__stall_count = stall_cnt_q;
`else
  assign o__pop_count   = '0;
  assign o__stall_count = '0;
`endif

endmodule

// File: tb/tb_pifo_dequeue_pacer.sv
// Directed-plus-random bench for pifo_dequeue_pacer against a cycle-level
// reference model with a sorted-queue PIFO.
module tb_pifo_dequeue_pacer;

  localparam int D = 8;
  localparam int P = 4;
  localparam int S_RUN = 0, S_PAUSE = 1, S_FLUSH = 2;
`ifdef PIFO_DEQ_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, pifo_valid, pifo_ready, pifo_clear, enq, pause, clr;
  logic        out_valid, dready;
  logic [7:0]  pifo_prio, pifo_data, out_prio, out_data;
  logic [3:0]  tokens;
  logic [31:0] pop_count, stall_count;

  pifo_dequeue_pacer #(
    .MAX_PRIORITY(256), .DATA_WIDTH(8), .BUCKET_DEPTH(D), .REFILL_PERIOD(P), .CNT_WIDTH(32)
  ) dut (
    .clk                  (clk),
    .reset                (rst),
    .i__pifo_valid        (pifo_valid),
    .i__pifo_priority     (pifo_prio),
    .i__pifo_data         (pifo_data),
    .o__pifo_ready        (pifo_ready),
    .o__pifo_clear_all    (pifo_clear),
    .i__enq_active        (enq),
    .i__pause             (pause),
    .i__clear_all         (clr),
    .o__data_out_valid    (out_valid),
    .o__data_out_priority (out_prio),
    .o__data_out          (out_data),
    .i__data_out_ready    (dready),
    .o__tokens            (tokens),
    .o__pop_count         (pop_count),
    .o__stall_count       (stall_count)
  );

  int checks = 0;
  int failures = 0;

  logic [15:0] pq[$];   // {prio, data}, kept sorted by prio, FIFO among equals

  bit          m_valid;
  logic [7:0]  m_prio, m_data;
  int          m_tokens, m_phase, m_state;
  logic [31:0] m_pop, m_stall;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pq_push(input logic [7:0] p, input logic [7:0] d);
    int idx;
    idx = pq.size();
    for (int i = 0; i < pq.size(); i++) begin
      if (pq[i][15:8] > p) begin idx = i; break; end
    end
    pq.insert(idx, {p, d});
  endtask

  task automatic drive_pifo();
    logic [15:0] h;
    pifo_valid = (pq.size() > 0);
    h = (pq.size() > 0) ? pq[0] : 16'h0;
    pifo_prio = h[15:8];
    pifo_data = h[7:0];
  endtask

  task automatic m_reset();
    m_valid = 0; m_prio = 0; m_data = 0;
    m_tokens = D; m_phase = 0; m_state = S_RUN;
    m_pop = 0; m_stall = 0;
  endtask

  // One clock: check outputs against the model, then advance model and PIFO.
  task automatic cycle();
    bit exp_ready, pop, refill, clr_out, nonempty;
    int t;
    drive_pifo();
    #1;
    nonempty  = (pq.size() > 0);
    clr_out   = (m_state == S_FLUSH);
    exp_ready = !rst && (m_state == S_RUN) && !pause && !clr && !enq &&
                (m_tokens != 0) && (!m_valid || dready);
    pop       = exp_ready && nonempty;
    chk("pifo_ready", 32'(pifo_ready), 32'(exp_ready));
    chk("clear_all",  32'(pifo_clear), 32'(clr_out));
    chk("out_valid",  32'(out_valid),  32'(m_valid));
    chk("out_prio",   32'(out_prio),   32'(m_prio));
    chk("out_data",   32'(out_data),   32'(m_data));
    chk("tokens",     32'(tokens),     32'(m_tokens));
    chk("pop_count",  pop_count,   STATS ? m_pop   : 32'd0);
    chk("stall_count", stall_count, STATS ? m_stall : 32'd0);
    @(posedge clk);
    if (rst) begin
      m_reset();
    end else begin
      refill  = (m_phase == P - 1);
      m_phase = (m_phase + 1) % P;
      t = m_tokens + int'(refill) - int'(pop);
      m_tokens = (t > D) ? D : t;
      if (nonempty && m_state == S_RUN && m_tokens + int'(pop) - int'(refill) == 0) m_stall++;
      if (pop) m_pop++;
      if (clr || clr_out) m_valid = 0;
      else if (pop) begin m_valid = 1; m_prio = pq[0][15:8]; m_data = pq[0][7:0]; end
      else if (m_valid && dready) m_valid = 0;
      case (m_state)
        S_RUN:   m_state = clr ? S_FLUSH : (pause ? S_PAUSE : S_RUN);
        S_PAUSE: m_state = clr ? S_FLUSH : (pause ? S_PAUSE : S_RUN);
        default: m_state = pause ? S_PAUSE : S_RUN;
      endcase
    end
    if (clr_out) pq.delete();
    else if (pop) void'(pq.pop_front());
    if (enq) pq_push(8'($urandom_range(0, 255)), 8'($urandom));
    @(negedge clk);
  endtask

  initial begin
    bit reached;
    rst = 1; enq = 0; pause = 0; clr = 0; dready = 1;
    drive_pifo();
    repeat (3) @(posedge clk);
    @(negedge clk);
    m_reset();
    #1;
    chk("rst_ready",  32'(pifo_ready), 32'd0);
    chk("rst_valid",  32'(out_valid),  32'd0);
    chk("rst_prio",   32'(out_prio),   32'd0);
    chk("rst_tokens", 32'(tokens),     32'(D));
    chk("rst_clear",  32'(pifo_clear), 32'd0);
    rst = 0;

    // Pacing: 20 entries, burst of D pops then one per refill period.
    for (int i = 1; i <= 20; i++) pq_push(8'(i), 8'($urandom));
    repeat (40) cycle();

    // Backpressure with an entry held.
    for (int i = 0; i < 6; i++) pq_push(8'($urandom_range(0, 255)), 8'($urandom));
    for (int i = 0; i < 10 && !m_valid; i++) cycle();
    dready = 0;
    repeat (10) cycle();
    dready = 1;
    repeat (5) cycle();

    // Enqueue conflict on alternate cycles.
    for (int i = 0; i < 20; i++) begin enq = (i % 2 == 0); cycle(); end
    enq = 0;

    // Pause / resume mid-stream.
    for (int i = 0; i < 8; i++) pq_push(8'($urandom_range(0, 255)), 8'($urandom));
    repeat (3) cycle();
    pause = 1; repeat (6) cycle();
    pause = 0; repeat (6) cycle();

    // Clear with priority 5 held.
    clr = 1; cycle(); clr = 0; repeat (2) cycle();
    dready = 0;
    pq_push(8'd5, 8'hA5); pq_push(8'd9, 8'h09); pq_push(8'd12, 8'h0C);
    for (int i = 0; i < 10 && !m_valid; i++) cycle();
    #1 chk("clr_held_prio", 32'(out_prio), 32'd5);
    clr = 1; cycle(); clr = 0;
    repeat (3) cycle();

    // Randomized mix.
    for (int i = 0; i < 400; i++) begin
      if (pq.size() < 4) pq_push(8'($urandom_range(0, 255)), 8'($urandom));
      dready = ($urandom_range(0, 3) != 0);
      enq    = ($urandom_range(0, 9) < 3);
      pause  = ($urandom_range(0, 9) == 0);
      clr    = ($urandom_range(0, 31) == 0);
      cycle();
    end
    enq = 0; pause = 0; clr = 0;

    // Reset mid-operation with tokens=3 and an entry held.
    while (pq.size() < 40) pq_push(8'($urandom_range(0, 255)), 8'($urandom));
    dready = 0;
    repeat (40) cycle();
    dready = 1;
    reached = 0;
    for (int i = 0; i < 30; i++) begin
      if (m_tokens == 3 && m_valid) begin reached = 1; break; end
      cycle();
    end
    chk("reach_tokens3", 32'(reached), 32'd1);
    rst = 1; cycle(); rst = 0;
    #1;
    chk("rstmid_valid",  32'(out_valid),  32'd0);
    chk("rstmid_tokens", 32'(tokens),     32'(D));
    chk("rstmid_pops",   pop_count,       32'd0);
    chk("rstmid_stalls", stall_count,     32'd0);
    repeat (4) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
